// File: rtl/rr_scale_mux.sv
// ============================================================================
// Module   : rr_scale_mux
// Brief    : NUM_CH-to-1 round-robin valid/ready mux with a one-entry
//            registered output stage. Optional parity output is enabled with
//            the RR_SCALE_MUX_PARITY_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_scale_mux #(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch
`ifdef RR_SCALE_MUX_PARITY_EN
    ,
    output logic                    out_par
`endif
);

    localparam logic [CH_W:0]   C_NUM  = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] C_LAST = CH_W'(NUM_CH - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    logic [NUM_CH-1:0] w_req;
    logic [CH_W-1:0]   w_gnt;
    logic [CH_W:0]     w_idx;
    logic              w_found;
    logic              w_load;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_sel;

    assign w_req  = in_valid & ch_en;
    assign w_load = (state_q == ST_EMPTY) | out_ready;
    assign w_xfer = w_found & w_load;

    // Rotating priority search: index ptr first, wrapping past NUM_CH-1.
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = {1'b0, ptr_q} + (CH_W+1)'(k);
            if (w_idx >= C_NUM) begin
                w_idx = w_idx - C_NUM;
            end
            if (!w_found && w_req[w_idx[CH_W-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == w_gnt) begin
                w_sel = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Held off during reset so no producer sees a handshake that is discarded.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
            assign in_ready[gi] = !rst && w_xfer && (w_gnt == CH_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        ch_d    = ch_q;
        if (w_xfer) begin
            state_d = ST_FULL;
            data_d  = w_sel;
            ch_d    = w_gnt;
            ptr_d   = (w_gnt == C_LAST) ? '0 : w_gnt + CH_W'(1);
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

`ifdef RR_SCALE_MUX_PARITY_EN
    logic par_q, par_d;

    assign par_d = w_xfer ? ^w_sel : par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign out_par = par_q;
`endif

endmodule

`default_nettype wire
